// File: rtl/hazard_unit_md.sv
// hazard_unit_md: bypass selects, load-use stall and single mult/div scoreboard; HAZARD_BYPASS_EN enables bypassing (otherwise RAW hazards stall)
module hazard_unit_md #(
    parameter int ADDR_W    = 5,
    parameter int MD_CYCLES = 33
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] fd_rs_i,
    input  logic [ADDR_W-1:0] fd_rt_i,
    input  logic [ADDR_W-1:0] fd_rd_i,
    input  logic              fd_uses_rs_i,
    input  logic              fd_uses_rt_i,
    input  logic              fd_we_i,
    input  logic              fd_is_md_i,
    input  logic [ADDR_W-1:0] dx_rs_i,
    input  logic [ADDR_W-1:0] dx_rt_i,
    input  logic [ADDR_W-1:0] dx_rd_i,
    input  logic              dx_we_i,
    input  logic              dx_is_lw_i,
    input  logic              dx_is_md_i,
    input  logic [ADDR_W-1:0] xm_rd_i,
    input  logic [ADDR_W-1:0] xm_rt_i,
    input  logic              xm_we_i,
    input  logic [ADDR_W-1:0] mw_rd_i,
    input  logic              mw_we_i,
    input  logic              md_ready_i,
    output logic              mx_a_o,
    output logic              mx_b_o,
    output logic              wx_a_o,
    output logic              wx_b_o,
    output logic              wm_o,
    output logic              stall_fd_o,
    output logic              bubble_dx_o,
    output logic              md_busy_o,
    output logic [ADDR_W-1:0] md_rd_o,
    output logic              md_wb_o,
    output logic              md_timeout_o
);
`ifdef HAZARD_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif
    localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] md_rd_q, md_rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              load_use, md_stall, raw_stall, start;

    // Same-cycle bypass selects (MX wins over WX); without bypassing, an FD read of any in-flight producer stalls instead
    always_comb begin
        mx_a_o    = BYP_EN && xm_we_i && xm_rd_i != '0 && dx_rs_i == xm_rd_i;
        mx_b_o    = BYP_EN && xm_we_i && xm_rd_i != '0 && dx_rt_i == xm_rd_i;
        wx_a_o    = BYP_EN && mw_we_i && mw_rd_i != '0 && dx_rs_i == mw_rd_i && !mx_a_o;
        wx_b_o    = BYP_EN && mw_we_i && mw_rd_i != '0 && dx_rt_i == mw_rd_i && !mx_b_o;
        wm_o      = BYP_EN && mw_we_i && mw_rd_i != '0 && xm_rt_i == mw_rd_i;
        raw_stall = !BYP_EN && (
            (fd_uses_rs_i && fd_rs_i != '0 && ((dx_we_i && fd_rs_i == dx_rd_i) ||
                                               (xm_we_i && fd_rs_i == xm_rd_i) ||
                                               (mw_we_i && fd_rs_i == mw_rd_i))) ||
            (fd_uses_rt_i && fd_rt_i != '0 && ((dx_we_i && fd_rt_i == dx_rd_i) ||
                                               (xm_we_i && fd_rt_i == xm_rd_i) ||
                                               (mw_we_i && fd_rt_i == mw_rd_i))));
    end

    // Load-use and pending mult/div hazards freeze FD and bubble DX; a new mult/div only starts from IDLE when FD is not stalled
    always_comb begin
        load_use    = dx_is_lw_i && dx_rd_i != '0 &&
                      ((fd_uses_rs_i && fd_rs_i == dx_rd_i) || (fd_uses_rt_i && fd_rt_i == dx_rd_i));
        md_stall    = state_q != IDLE && ((fd_uses_rs_i && fd_rs_i == md_rd_q) ||
                                          (fd_uses_rt_i && fd_rt_i == md_rd_q) ||
                                          (fd_we_i && fd_rd_i == md_rd_q) || fd_is_md_i);
        stall_fd_o  = load_use || md_stall || raw_stall;
        bubble_dx_o = stall_fd_o;
        start       = state_q == IDLE && dx_is_md_i && dx_rd_i != '0 && !stall_fd_o;
    end

    // Scoreboard next state: count down while busy, finish on md_ready or on timeout, then one writeback cycle
    always_comb begin
        state_d   = state_q;
        md_rd_d   = md_rd_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = BUSY;
                md_rd_d = dx_rd_i;
                cnt_d   = CW'(MD_CYCLES - 1);
            end
            BUSY: if (md_ready_i) begin
                state_d = DONE;
            end else if (cnt_q == '0) begin
                state_d   = DONE;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scoreboard registers; reset abandons any operation without a writeback
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            md_rd_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_rd_q   <= md_rd_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign md_busy_o    = state_q != IDLE;
    assign md_wb_o      = state_q == DONE;
    assign md_rd_o      = md_rd_q;
    assign md_timeout_o = timeout_q;
endmodule

// File: tb/tb_hazard_unit_md.sv
// tb_hazard_unit_md: directed checks of bypass, stalls and mult/div scoreboard (default and MD_CYCLES=4 instances)
module tb_hazard_unit_md;
`ifdef HAZARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0, rst_n;
    logic [4:0] fd_rs, fd_rt, fd_rd, dx_rs, dx_rt, dx_rd, xm_rd, xm_rt, mw_rd;
    logic fd_uses_rs, fd_uses_rt, fd_we, fd_is_md, dx_we, dx_is_lw, dx_is_md, xm_we, mw_we, md_ready;
    logic mx_a, mx_b, wx_a, wx_b, wm, stall_fd, bubble_dx, md_busy, md_wb, md_to;
    logic [4:0] md_rd;
    logic t_mx_a, t_mx_b, t_wx_a, t_wx_b, t_wm, t_stall, t_bubble, t_busy, t_wb, t_to;
    logic [4:0] t_md_rd;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    hazard_unit_md dut (
        .clk_i(clk), .rst_ni(rst_n),
        .fd_rs_i(fd_rs), .fd_rt_i(fd_rt), .fd_rd_i(fd_rd),
        .fd_uses_rs_i(fd_uses_rs), .fd_uses_rt_i(fd_uses_rt), .fd_we_i(fd_we), .fd_is_md_i(fd_is_md),
        .dx_rs_i(dx_rs), .dx_rt_i(dx_rt), .dx_rd_i(dx_rd),
        .dx_we_i(dx_we), .dx_is_lw_i(dx_is_lw), .dx_is_md_i(dx_is_md),
        .xm_rd_i(xm_rd), .xm_rt_i(xm_rt), .xm_we_i(xm_we),
        .mw_rd_i(mw_rd), .mw_we_i(mw_we), .md_ready_i(md_ready),
        .mx_a_o(mx_a), .mx_b_o(mx_b), .wx_a_o(wx_a), .wx_b_o(wx_b), .wm_o(wm),
        .stall_fd_o(stall_fd), .bubble_dx_o(bubble_dx), .md_busy_o(md_busy),
        .md_rd_o(md_rd), .md_wb_o(md_wb), .md_timeout_o(md_to)
    );

    hazard_unit_md #(.ADDR_W(5), .MD_CYCLES(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .fd_rs_i(fd_rs), .fd_rt_i(fd_rt), .fd_rd_i(fd_rd),
        .fd_uses_rs_i(fd_uses_rs), .fd_uses_rt_i(fd_uses_rt), .fd_we_i(fd_we), .fd_is_md_i(fd_is_md),
        .dx_rs_i(dx_rs), .dx_rt_i(dx_rt), .dx_rd_i(dx_rd),
        .dx_we_i(dx_we), .dx_is_lw_i(dx_is_lw), .dx_is_md_i(dx_is_md),
        .xm_rd_i(xm_rd), .xm_rt_i(xm_rt), .xm_we_i(xm_we),
        .mw_rd_i(mw_rd), .mw_we_i(mw_we), .md_ready_i(md_ready),
        .mx_a_o(t_mx_a), .mx_b_o(t_mx_b), .wx_a_o(t_wx_a), .wx_b_o(t_wx_b), .wm_o(t_wm),
        .stall_fd_o(t_stall), .bubble_dx_o(t_bubble), .md_busy_o(t_busy),
        .md_rd_o(t_md_rd), .md_wb_o(t_wb), .md_timeout_o(t_to)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        {fd_rs, fd_rt, fd_rd, dx_rs, dx_rt, dx_rd, xm_rd, xm_rt, mw_rd} = '0;
        {fd_uses_rs, fd_uses_rt, fd_we, fd_is_md, dx_we, dx_is_lw, dx_is_md, xm_we, mw_we, md_ready} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", md_busy, 0);
        chk("rst_md_rd", md_rd, 0);
        chk("rst_wb", md_wb, 0);
        chk("rst_timeout", md_to, 0);
        chk("rst_bypass", {mx_a, mx_b, wx_a, wx_b, wm}, 0);
        chk("rst_stall", {stall_fd, bubble_dx}, 0);
        chk("rst4_state", {t_busy, t_wb, t_to, t_md_rd}, 0);
        tick();
        rst_n = 1'b1;

        // bypass selects and priority
        tick();
        clr();
        dx_rs = 3; xm_rd = 3; xm_we = 1; mw_rd = 3; mw_we = 1;
        #1;
        chk("mx_a", mx_a, BYP);
        chk("wx_a_masked", wx_a, 0);
        chk("byp_no_stall", stall_fd, 0);
        xm_rd = 0;
        #1;
        chk("wx_a", wx_a, BYP);
        chk("mx_a_xm0", mx_a, 0);
        dx_rt = 3;
        #1;
        chk("wx_b", wx_b, BYP);
        chk("mx_b_off", mx_b, 0);
        xm_rt = 3;
        #1;
        chk("wm", wm, BYP);
        mw_we = 0;
        #1;
        chk("mw_we0", {wx_a, wx_b, wm}, 0);
        clr();
        xm_we = 1; mw_we = 1;
        #1;
        chk("reg0_bypass", {mx_a, mx_b, wx_a, wx_b, wm}, 0);

        // load-use stall
        tick();
        clr();
        dx_is_lw = 1; dx_rd = 5; fd_rs = 5; fd_uses_rs = 1;
        #1;
        chk("lu_stall", stall_fd, 1);
        chk("lu_bubble", bubble_dx, 1);
        fd_rs = 0; dx_rd = 0;
        #1;
        chk("lu_reg0", {stall_fd, bubble_dx}, 0);
        fd_uses_rs = 0; fd_rt = 5; dx_rd = 5; fd_uses_rt = 1;
        #1;
        chk("lu_rt", stall_fd, 1);
        fd_uses_rt = 0;
        #1;
        chk("lu_rt_unused", stall_fd, 0);

        // RAW stall when bypassing is absent
        tick();
        clr();
        fd_rs = 9; fd_uses_rs = 1; xm_rd = 9; xm_we = 1;
        #1;
        chk("raw_xm_stall", stall_fd, !BYP);
        chk("raw_xm_bubble", bubble_dx, !BYP);
        chk("raw_bypass0", {mx_a, mx_b, wx_a, wx_b, wm}, 0);
        clr();
        fd_rt = 4; fd_uses_rt = 1; dx_rd = 4; dx_we = 1;
        #1;
        chk("raw_dx_stall", stall_fd, !BYP);
        clr();
        fd_uses_rs = 1; mw_we = 1;
        #1;
        chk("raw_reg0", stall_fd, 0);

        // mult/div to r7, ready in 10th busy cycle; dut4 times out meanwhile
        tick();
        clr();
        dx_is_md = 1; dx_rd = 7;
        #1;
        chk("md_start_same", md_busy, 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            clr();
            dx_is_md = (k == 3);
            dx_rd = (k == 3) ? 5'd9 : 5'd0;
            fd_rt = 7; fd_uses_rt = 1;
            md_ready = (k == 10);
            #1;
            chk($sformatf("md_busy_%0d", k), md_busy, k <= 11);
            chk($sformatf("md_wb_%0d", k), md_wb, k == 11);
            chk($sformatf("md_rd_%0d", k), md_rd, 7);
            chk($sformatf("md_stall_%0d", k), stall_fd, k <= 11);
            chk($sformatf("md_to_%0d", k), md_to, 0);
            chk($sformatf("to_busy_%0d", k), t_busy, k <= 5);
            chk($sformatf("to_wb_%0d", k), t_wb, k == 5);
            chk($sformatf("to_flag_%0d", k), t_to, k >= 5);
            chk($sformatf("to_md_rd_%0d", k), t_md_rd, 7);
        end

        // md_ready in IDLE and dx_rd==0 start are ignored; timeout sticks
        clr();
        md_ready = 1; dx_is_md = 1;
        tick();
        clr();
        #1;
        chk("idle_ignore", {md_busy, md_wb, t_busy, t_wb}, 0);
        chk("to_sticky", t_to, 1);
        tick();
        chk("idle_ignore2", {md_busy, md_wb, t_busy, t_wb}, 0);
        chk("to_sticky2", t_to, 1);

        // reset mid-operation
        dx_is_md = 1; dx_rd = 12;
        tick();
        clr();
        chk("rb_busy", md_busy, 1);
        chk("rb_md_rd", md_rd, 12);
        tick();
        chk("rb_busy2", md_busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("rb_cleared", {md_busy, md_wb, md_rd}, 0);
        chk("rb_to_cleared", t_to, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rb_no_wb_%0d", k), {md_wb, md_busy, t_wb, t_busy}, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
